// File: rtl/hc595_rx_pkg.sv
// Shared constants for the 74HC595 seven-segment bus: frame geometry and the
// active-low segment codes for hex digits 0..F (dp off), also used by the driver.
package hc595_rx_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int SEG_W_DEF  = 8;
    localparam int SEL_W_DEF  = 6;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

endpackage

// File: rtl/hc595_rx_seg7_decode.sv
// Combinational inverse of the segment table: active-low seg[6:0] back to a hex
// nibble, with valid low for any pattern that is not one of the 16 codes.
module seg7_decode
    import hc595_rx_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        valid  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_0[6:0]: nibble = 4'h0;
            SEG_1[6:0]: nibble = 4'h1;
            SEG_2[6:0]: nibble = 4'h2;
            SEG_3[6:0]: nibble = 4'h3;
            SEG_4[6:0]: nibble = 4'h4;
            SEG_5[6:0]: nibble = 4'h5;
            SEG_6[6:0]: nibble = 4'h6;
            SEG_7[6:0]: nibble = 4'h7;
            SEG_8[6:0]: nibble = 4'h8;
            SEG_9[6:0]: nibble = 4'h9;
            SEG_A[6:0]: nibble = 4'hA;
            SEG_B[6:0]: nibble = 4'hB;
            SEG_C[6:0]: nibble = 4'hC;
            SEG_D[6:0]: nibble = 4'hD;
            SEG_E[6:0]: nibble = 4'hE;
            SEG_F[6:0]: nibble = 4'hF;
            default:    valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/hc595_rx.sv
// Receiver for the 74HC595 display bus: oversamples ds/shcp/stcp/oe, rebuilds each
// latched frame and decodes the segment pattern into per-digit hex and error flags.
module hc595_rx
    import hc595_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEG_W  = SEG_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 ds,
    input  logic                 shcp,
    input  logic                 stcp,
    input  logic                 oe,
    output logic [DATA_W-1:0]    frame_data,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic                 sel_err,
    output logic [4*SEL_W-1:0]   digits,
    output logic [SEL_W-1:0]     dp,
    output logic [SEL_W-1:0]     digit_bad,
    output logic                 display_en
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    logic [2:0]         shcp_sync;
    logic [2:0]         stcp_sync;
    logic [2:0]         ds_dly;
    logic               oe_sync;
    logic               shcp_rise;
    logic               stcp_rise;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SEL_W-1:0]   sel_next;
    logic               sel_one_hot;
    logic               dec_valid;
    logic [3:0]         dec_nibble;

    // Two flops synchronise, the third gives edge detect; the edge pulse is then
    // registered so ds_dly[2] (the ds seen with the first shcp sample) lines up.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shcp_sync  <= '0;
            stcp_sync  <= '0;
            ds_dly     <= '0;
            oe_sync    <= 1'b0;
            shcp_rise  <= 1'b0;
            stcp_rise  <= 1'b0;
            display_en <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic so each stage sees the previous stage's old value.
            shcp_sync  <= {shcp_sync[1:0], shcp};
            stcp_sync  <= {stcp_sync[1:0], stcp};
            ds_dly     <= {ds_dly[1:0], ds};
            oe_sync    <= oe;
            shcp_rise  <= shcp_sync[1] & ~shcp_sync[2];
            stcp_rise  <= stcp_sync[1] & ~stcp_sync[2];
            display_en <= ~oe_sync;
        end
    end

    assign sel_next    = shift_reg[SEL_W-1:0];
    assign sel_one_hot = (sel_next != '0) && ((sel_next & (sel_next - SEL_W'(1))) == '0);

    // A coincident shift and latch: the latch takes the pre-shift value and the
    // new bit already counts toward the next frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            if (shcp_rise) begin
                shift_reg <= {shift_reg[DATA_W-2:0], ds_dly[2]};
            end

            if (stcp_rise) begin
                frame_data  <= shift_reg;
                frame_valid <= 1'b1;
                frame_err   <= (bit_cnt != CNT_W'(DATA_W));
                sel_err     <= ~sel_one_hot;
                bit_cnt     <= shcp_rise ? CNT_W'(1) : '0;
            end else begin
                frame_valid <= 1'b0;
                frame_err   <= 1'b0;
                sel_err     <= 1'b0;
                if (shcp_rise && (bit_cnt != '1)) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    seg7_decode u_decode (
        .seg    (frame_data[DATA_W-2 -: SEG_W-1]),
        .valid  (dec_valid),
        .nibble (dec_nibble)
    );

    // Digit registers follow the latched frame by one cycle; an unmatched
    // pattern flags the digit but keeps its previous nibble.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            digits    <= '0;
            dp        <= '0;
            digit_bad <= '0;
        end else if (frame_valid && !sel_err) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (frame_data[i]) begin
                    dp[i]        <= ~frame_data[DATA_W-1];
                    digit_bad[i] <= ~dec_valid;
                    if (dec_valid) begin
                        digits[4*i +: 4] <= dec_nibble;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hc595_rx.sv
// Directed bench for hc595_rx: a frame-level model predicts every latched frame
// and the resulting digit state; literal checks pin the model to known values.
module tb_hc595_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        ds, shcp, stcp, oe;
    logic [13:0] frame_data;
    logic        frame_valid, frame_err, sel_err;
    logic [23:0] digits;
    logic [5:0]  dp, digit_bad;
    logic        display_en;

    hc595_rx dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .ds          (ds),
        .shcp        (shcp),
        .stcp        (stcp),
        .oe          (oe),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel_err     (sel_err),
        .digits      (digits),
        .dp          (dp),
        .digit_bad   (digit_bad),
        .display_en  (display_en)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        logic [13:0] frame;
        logic        ferr;
        logic        serr;
        logic [23:0] dig;
        logic [5:0]  dpv;
        logic [5:0]  bad;
    } exp_t;

    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [13:0] m_shift;
    int          m_cnt;
    logic [3:0]  m_dig [6];
    logic [5:0]  m_dp, m_bad;
    exp_t        exp_q [$];

    task automatic model_reset();
        m_shift = '0;
        m_cnt   = 0;
        for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
        m_dp  = '0;
        m_bad = '0;
        exp_q.delete();
    endtask

    task automatic model_shift(input logic b);
        m_shift = {m_shift[12:0], b};
        m_cnt   = (m_cnt >= 15) ? 15 : m_cnt + 1;
    endtask

    task automatic model_latch();
        exp_t       e;
        logic [7:0] seg;
        logic [5:0] sel;
        int         hit;
        seg = m_shift[13:6];
        sel = m_shift[5:0];
        e.frame = m_shift;
        e.ferr  = (m_cnt != 14);
        e.serr  = ($countones(sel) != 1);
        if (!e.serr) begin
            hit = -1;
            for (int n = 0; n < 16; n++) begin
                if (seg_tab[n][6:0] == seg[6:0]) hit = n;
            end
            for (int i = 0; i < 6; i++) begin
                if (sel[i]) begin
                    m_dp[i]  = ~seg[7];
                    m_bad[i] = (hit < 0);
                    if (hit >= 0) m_dig[i] = 4'(hit);
                end
            end
        end
        for (int i = 0; i < 6; i++) e.dig[4*i +: 4] = m_dig[i];
        e.dpv = m_dp;
        e.bad = m_bad;
        exp_q.push_back(e);
        m_cnt = 0;
    endtask

    // ---------------- compare process ----------------
    exp_t        cur, pend;
    logic        chk_dig    = 1'b0;
    logic        prev_valid = 1'b0;
    int          n_frames   = 0;
    logic [13:0] last_frame;
    logic        last_ferr, last_serr;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            chk_dig    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (chk_dig) begin
                check("digits", 32'(digits), 32'(pend.dig));
                check("dp", 32'(dp), 32'(pend.dpv));
                check("digit_bad", 32'(digit_bad), 32'(pend.bad));
                chk_dig = 1'b0;
            end
            if (frame_valid) begin
                check("valid_single_cycle", 32'(prev_valid), 32'(0));
                check("frame_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("frame_data", 32'(frame_data), 32'(cur.frame));
                    check("frame_err", 32'(frame_err), 32'(cur.ferr));
                    check("sel_err", 32'(sel_err), 32'(cur.serr));
                    pend    = cur;
                    chk_dig = 1'b1;
                end
                n_frames++;
                last_frame = frame_data;
                last_ferr  = frame_err;
                last_serr  = sel_err;
            end else begin
                check("err_idle", 32'({frame_err, sel_err}), 32'(0));
            end
            prev_valid = frame_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic with_latch);
        ds = b;
        tick(2);
        shcp = 1'b1;
        if (with_latch) begin
            stcp = 1'b1;
            model_latch();
        end
        model_shift(b);
        tick(2);
        shcp = 1'b0;
        stcp = 1'b0;
        if (with_latch) tick(5);
    endtask

    task automatic latch();
        tick(2);
        stcp = 1'b1;
        model_latch();
        tick(2);
        stcp = 1'b0;
        tick(5);
    endtask

    task automatic send_bits(input logic [13:0] f, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(f[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] seg, input logic [5:0] sel);
        send_bits({seg, sel}, 14);
        latch();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
        model_reset();
        tick(3);
        check("rst_frame_data", 32'(frame_data), 32'(0));
        check("rst_frame_valid", 32'(frame_valid), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_sel_err", 32'(sel_err), 32'(0));
        check("rst_digits", 32'(digits), 32'(0));
        check("rst_dp", 32'(dp), 32'(0));
        check("rst_digit_bad", 32'(digit_bad), 32'(0));
        check("rst_display_en", 32'(display_en), 32'(0));
        sys_rst_n = 1'b1;
        tick(3);

        // First frame: "0" on digit 0
        send_frame(8'hC0, 6'b000001);
        check("lit_first_frame", 32'(last_frame), 32'h3001);
        check("lit_first_ferr", 32'(last_ferr), 32'(0));
        check("lit_first_pulses", 32'(n_frames), 32'(1));
        check("lit_first_nibble", 32'(digits[3:0]), 32'(0));
        check("lit_first_dp", 32'(dp[0]), 32'(0));

        // Six digits 1..6
        send_frame(8'hF9, 6'b000001);
        send_frame(8'hA4, 6'b000010);
        send_frame(8'hB0, 6'b000100);
        send_frame(8'h99, 6'b001000);
        send_frame(8'h92, 6'b010000);
        send_frame(8'h82, 6'b100000);
        check("lit_six_digits", 32'(digits), 32'h654321);
        check("lit_six_bad", 32'(digit_bad), 32'(0));

        // "8" with dp on, on digit 1
        send_frame(8'h00, 6'b000010);
        check("lit_dp8_digits", 32'(digits), 32'h654381);
        check("lit_dp8_dp", 32'(dp), 32'(6'b000010));

        // Blank on digit 2: flagged, nibble kept
        send_frame(8'hFF, 6'b000100);
        check("lit_blank_bad", 32'(digit_bad), 32'(6'b000100));
        check("lit_blank_digits", 32'(digits), 32'h654381);

        // Blank with dp on, on digit 3
        send_frame(8'h7F, 6'b001000);
        check("lit_dpblank_bad", 32'(digit_bad), 32'(6'b001100));
        check("lit_dpblank_dp", 32'(dp), 32'(6'b001010));

        // Short frame (13 bits)
        send_bits({8'hF9, 6'b000001}, 13);
        latch();
        check("lit_short_ferr", 32'(last_ferr), 32'(1));

        // Long frame (15 bits): flagged but still applied
        send_bit(1'b0, 1'b0);
        send_frame(8'hC0, 6'b000001);
        check("lit_long_ferr", 32'(last_ferr), 32'(1));
        check("lit_long_frame", 32'(last_frame), 32'h3001);
        check("lit_long_digits", 32'(digits), 32'h654380);

        // Two select bits: no digit change
        send_frame(8'hA4, 6'b000011);
        check("lit_sel_err", 32'(last_serr), 32'(1));
        check("lit_sel_digits", 32'(digits), 32'h654380);

        // Coincident shcp/stcp: latch pre-shift frame, bit counts toward next
        begin
            logic [13:0] f1, f2;
            f1 = {8'hF9, 6'b000010};
            f2 = {8'h92, 6'b000100};
            send_bits(f1, 14);
            send_bit(f2[13], 1'b1);
            check("lit_coinc_ferr1", 32'(last_ferr), 32'(0));
            check("lit_coinc_frame1", 32'(last_frame), 32'(f1));
            send_bits(f2, 13);
            latch();
            check("lit_coinc_ferr2", 32'(last_ferr), 32'(0));
            check("lit_coinc_digits", 32'(digits), 32'h654510);
        end

        // Reset mid-frame
        send_bits({8'hB0, 6'b000001}, 7);
        tick(4);
        sys_rst_n = 1'b0;
        model_reset();
        tick(2);
        sys_rst_n = 1'b1;
        tick(2);
        check("lit_midrst_digits", 32'(digits), 32'(0));
        send_frame(8'h99, 6'b010000);
        check("lit_midrst_ferr", 32'(last_ferr), 32'(0));
        check("lit_midrst_digits2", 32'(digits), 32'h040000);

        // Output enable
        check("oe_off", 32'(display_en), 32'(0));
        oe = 1'b0;
        tick(1);
        check("oe_lag1", 32'(display_en), 32'(0));
        tick(1);
        check("oe_lag2", 32'(display_en), 32'(1));

        tick(4);
        check("frames_outstanding", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
